// File: rtl/itch_axis_byte_tx.sv
// rtl/itch_axis_byte_tx.sv - byte stream to AXI-Stream master with lane packer and word FIFO
module itch_axis_byte_tx #(
   parameter int C_M_AXIS_TDATA_WIDTH = 32,
   parameter int FIFO_DEPTH           = 8,
   parameter int MSG_CNT_WIDTH        = 16
) (
   input  logic                                M_AXIS_ACLK,
   input  logic                                M_AXIS_ARESET,
   input  logic [7:0]                          tx_byte,
   input  logic                                tx_valid,
   input  logic                                tx_last,
   output logic                                tx_ready,
   output logic                                M_AXIS_TVALID,
   output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
   output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
   output logic                                M_AXIS_TLAST,
   input  logic                                M_AXIS_TREADY,
   output logic [MSG_CNT_WIDTH-1:0]            msg_count,
   output logic                                busy
);

   localparam int W  = C_M_AXIS_TDATA_WIDTH;
   localparam int L  = W / 8;
   localparam int LW = $clog2(L);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   logic [LW-1:0] lane;
   logic [W-1:0]  pack_data;
   logic [L-1:0]  pack_strb;

   logic [W-1:0]  mem_data [FIFO_DEPTH];
   logic [L-1:0]  mem_strb [FIFO_DEPTH];
   logic          mem_last [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic          accept;
   logic          complete;
   logic          push;
   logic          pop;
   logic [W-1:0]  word_data;
   logic [L-1:0]  word_strb;

   // Every accepted byte is guaranteed FIFO space, so the packer never needs its own stall.
   assign tx_ready = !M_AXIS_ARESET && (count < CW'(FIFO_DEPTH));
   assign accept   = tx_valid && tx_ready;
   assign pop      = M_AXIS_TVALID && M_AXIS_TREADY;

   always_comb begin
      word_data = pack_data;
      word_strb = pack_strb;
      word_data[{lane, 3'b000} +: 8] = tx_byte;
      word_strb[lane] = 1'b1;
      complete = (lane == LW'(L - 1)) || tx_last;
      push     = accept && complete;
   end

   always_ff @(posedge M_AXIS_ACLK) begin
      if (M_AXIS_ARESET) begin
         lane      <= '0;
         pack_data <= '0;
         pack_strb <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         msg_count <= '0;
         for (int k = 0; k < FIFO_DEPTH; k++) begin
            mem_data[k] <= '0;
            mem_strb[k] <= '0;
            mem_last[k] <= 1'b0;
         end
      end else begin
         if (accept) begin
            if (complete) begin
               lane      <= '0;
               pack_data <= '0;
               pack_strb <= '0;
            end else begin
               lane      <= lane + LW'(1);
               pack_data <= word_data;
               pack_strb <= word_strb;
            end
         end
         if (push) begin
            mem_data[wr_ptr] <= word_data;
            mem_strb[wr_ptr] <= word_strb;
            mem_last[wr_ptr] <= tx_last;
            wr_ptr           <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
            if (mem_last[rd_ptr])
               msg_count <= msg_count + MSG_CNT_WIDTH'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign M_AXIS_TVALID = (count != '0);
   assign M_AXIS_TDATA  = mem_data[rd_ptr];
   assign M_AXIS_TSTRB  = mem_strb[rd_ptr];
   assign M_AXIS_TLAST  = mem_last[rd_ptr];
   assign busy          = (lane != '0) || (count != '0);

endmodule

// File: doc/itch_axis_byte_tx.md
Name: itch_axis_byte_tx

Overview:
- AXI-Stream master for the ITCH datapath; the transmit-side counterpart of the AXIS slave that feeds the parser byte-wise.
- Accepts a byte stream with message boundaries from internal logic (test generator, loopback, order/response path).
- Packs bytes little-endian into TDATA words, buffers them in a word FIFO and emits them as AXIS beats with TSTRB and TLAST, honouring TREADY backpressure.

Parameters:
- C_M_AXIS_TDATA_WIDTH, 32, TDATA width; multiple of 8, ≥16; lanes L = width/8.
- FIFO_DEPTH, 8, word FIFO depth; power of 2, ≥2.
- MSG_CNT_WIDTH, 16, width of the sent-message counter.

Ports:
- M_AXIS_ACLK  in  1  clock, single domain.
- M_AXIS_ARESET  in  1  synchronous reset, active-high.
- tx_byte  in  8  message byte from internal logic.
- tx_valid  in  1  tx_byte valid.
- tx_last  in  1  tx_byte is the final byte of its message.
- tx_ready  out  1  byte accepted when tx_valid && tx_ready.
- M_AXIS_TVALID  out  1  beat valid.
- M_AXIS_TDATA  out  C_M_AXIS_TDATA_WIDTH  packed bytes; first byte in [7:0].
- M_AXIS_TSTRB  out  L  lane-valid mask.
- M_AXIS_TLAST  out  1  final beat of message.
- M_AXIS_TREADY  in  1  downstream ready.
- msg_count  out  MSG_CNT_WIDTH  messages fully sent (TLAST handshakes), wraps.
- busy  out  1  partial word held or FIFO non-empty.

Behaviour:
- Reset (synchronous, active-high, M_AXIS_ARESET): TVALID=0, TDATA=0, TSTRB=0, TLAST=0, msg_count=0, busy=0, lane index=0, FIFO empty, packer data/strb cleared. tx_ready=0 while reset is asserted. A message in flight at reset is discarded entirely: partial packer contents and FIFO words are dropped, and no TLAST is emitted for it.
- Packer:
  - Lane index i in 0..L-1; an accepted byte is written to lane i and its strb bit is set.
  - A word completes when i==L-1 or tx_last=1. The completed word (data, strb, last=tx_last) is pushed into the FIFO on the same accepting cycle. The packer then clears and i returns to 0.
  - Otherwise i increments.
  - A message therefore never shares a word with the next one.
  - Unused lanes of a partial word: data 0, strb 0. Strb is always contiguous from lane 0.
- tx_ready = !reset && (fifo_count < FIFO_DEPTH), registered from the count. A pop in the same cycle does not raise tx_ready while full; this is one cycle pessimistic and acceptable.
- tx_ready is independent of the packer: only word-completing bytes push, and every accepted byte is guaranteed FIFO space.
- FIFO:
  - Synchronous, registered head.
  - Push and pop in the same cycle keep the count unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - The full condition blocks input; the empty condition deasserts TVALID.
- Output:
  - TVALID = (fifo_count != 0); TDATA/TSTRB/TLAST present the head entry.
  - Latency: the cycle after the completing byte's handshake, the word is at the head when the FIFO was empty.
  - A beat transfers on TVALID && TREADY.
  - While TVALID=1 && TREADY=0, TDATA/TSTRB/TLAST/TVALID hold stable (AXIS rule); TVALID never drops without a handshake.
  - TREADY asserted while TVALID=0 has no effect.
- msg_count increments by 1 on each TVALID && TREADY && TLAST, and wraps from all-ones to 0.
- busy = (i != 0) || (fifo_count != 0).
- tx_valid asserted with tx_ready=0: no state change, byte not consumed; the source must hold it.

Test Plan:
- Single 4-byte message 0x41,0x42,0x43,0x44 (last on 0x44), TREADY=1 → one beat TDATA=0x44434241, TSTRB=0xF, TLAST=1, TVALID 1 cycle after the last byte; msg_count=1.
- 6-byte message 0x01..0x06 → beat 0x04030201/STRB 0xF/LAST 0, then beat 0x00000605/STRB 0x3/LAST 1.
- 1-byte message 0x53 followed immediately by 2-byte message 0xAA,0xBB → beats 0x00000053/0x1/1 and 0x0000BBAA/0x3/1; no lane sharing; msg_count=2.
- TREADY=0 while 10 four-byte messages stream in (FIFO_DEPTH=8) → tx_ready drops after the 8th word is pushed, TVALID held with TDATA stable. Release TREADY → all 10 words emitted in order, msg_count=10, busy returns to 0.
- Random TREADY toggling (50%) over 200 random-length (1–40 byte) messages → scoreboard byte-exact match, TLAST count equals message count, and no TDATA/TSTRB/TLAST change while TVALID=1 and TREADY=0.
- Reset asserted after byte 2 of a 7-byte message with 1 word queued and TREADY=0 → next cycle TVALID=0, busy=0, msg_count=0. A following 3-byte message emits a single beat with TSTRB=0x7 and TLAST=1.
